mcp4922_dac_tx: RTL and testbench
=================================

Name: mcp4922_dac_tx

Overview:
Dual-channel SPI transmitter that drives an external MCP4922 12-bit DAC. It is the output-side counterpart of the 2-channel XADC capture path: fabric logic posts 12-bit codes per channel, and the block serialises them into 16-bit SPI frames. After all pending frames it pulses LDAC so both DAC outputs update simultaneously. The block runs entirely in the CLK12M domain and sits between control logic and the board DAC pins.

Parameters:
HALF_DIV, 6, SCK half-period in CLK12M cycles (6 gives 1 MHz SCK); legal range 2..255
GAIN_1X, 1, frame bit 13 (GA_n): 1 selects 1x gain, 0 selects 2x gain
VREF_BUF, 0, frame bit 14 (BUF): 1 selects buffered VREF

Ports:
CLK12M  in  1  system clock; all logic is clocked on its rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  write strobe; one write per cycle
in_ch  in  1  target channel: 0 = A, 1 = B
in_data  in  12  DAC code
in_ready  out  1  high whenever rst is low; writes are never refused
busy  out  1  high while any frame or the LDAC pulse is in progress, or while a write is pending
done  out  1  one-cycle pulse when ldac_n returns high
cs_n  out  1  SPI chip select, active low
sck  out  1  SPI clock, mode 0 (idle low)
sdi  out  1  SPI data, MSB first
ldac_n  out  1  DAC latch strobe, active low

Behaviour:
- Reset values: cs_n=1, sck=0, sdi=0, ldac_n=1, busy=0, done=0. Both pending flags are cleared and the FSM goes to IDLE. A reset asserted mid-frame aborts the frame immediately; the DAC does not latch a partial frame because cs_n rises before 16 clocks.
- Pending registers: there is one 12-bit register plus one flag per channel. An accepted write stores in_data and sets the flag for in_ch. A write to a channel that is already pending overwrites the stored value (latest value wins).
- Frame word: {ch, VREF_BUF, GAIN_1X, 1'b1 (SHDN_n), code[11:0]}.
- FSM states: IDLE, LOAD, SHIFT, CS_GAP, LDAC, FIN.
- IDLE: if either flag is set, go to LOAD; otherwise remain in IDLE.
- LOAD (1 cycle): select channel A if its flag is set, else channel B. Copy the frame word into the shift register and clear that channel's flag. If a write to the same channel occurs in the same cycle, the set wins and the new value becomes pending.
- SHIFT: cs_n=0 and sdi=bit15 from the first SHIFT cycle (cycle T).
  - sck rises at T+HALF_DIV·(2k+1) and falls at T+HALF_DIV·(2k+2), for k=0..15.
  - sdi advances to the next bit on each falling edge, except after the 16th.
  - After the 16th falling edge (T+32·HALF_DIV), cs_n=1 and the FSM enters CS_GAP.
- CS_GAP (HALF_DIV cycles): if any flag is set, go to LOAD; otherwise go to LDAC.
- LDAC: ldac_n=0 for HALF_DIV cycles, then go to FIN.
- FIN (1 cycle): ldac_n=1, done=1, busy=0 if no flag is set; then return to IDLE. If a write arrived in the meantime, the next cycle goes IDLE→LOAD.
- Latency: a write accepted at cycle W from IDLE gives LOAD at W+1 and cs_n low at W+2.
- Counters: the half-period counter is 8 bits and wraps only via explicit reload; the bit counter is 5 bits (0..16).
- Writes during SHIFT/CS_GAP/LDAC are queued. A write accepted during LDAC is sent after FIN and receives its own LDAC pulse.

Test Plan:
- Reset, then a single write (ch0, 0xABC), HALF_DIV=6 -> cs_n low 192 cycles; 16 sampled bits equal 0x3ABC; 6-cycle CS gap; ldac_n low 6 cycles; done pulses exactly once; busy drops with done.
- Back-to-back writes (ch1, 0x123) then (ch0, 0x7FF) in consecutive cycles -> channel A frame 0x37FF first, then B frame 0xB123; exactly one LDAC pulse, after the second frame.
- Overwrite: write ch0 0x111, then ch0 0x222 before LOAD -> only frame 0x3222 is sent.
- Write ch0 0x555 during the first frame's SHIFT -> a second frame 0x3555 follows after CS_GAP with no intermediate LDAC.
- Assert rst at bit 8 of a frame -> next cycle cs_n=1, sck=0, sdi=0, busy=0; no LDAC pulse; a later write produces a clean full frame.
- GAIN_1X=0, VREF_BUF=1, write ch1 0xFFF -> frame 0xDFFF; sdi is stable across every sck rising edge.

Source files
------------

// File: rtl/mcp4922_dac_tx_if.sv
// Write port of the MCP4922 transmitter: one 12-bit code per cycle, tagged with its channel.
interface mcp4922_dac_tx_if;
  logic        in_valid;
  logic        in_ch;
  logic [11:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_ch, output in_data, input in_ready);
  modport slave  (input in_valid, input in_ch, input in_data, output in_ready);
endinterface

// File: rtl/mcp4922_dac_tx.sv
// Dual-channel SPI transmitter for the MCP4922 DAC. Pending codes are sent as
// 16-bit mode-0 frames, then a single LDAC pulse updates both outputs together.
module mcp4922_dac_tx #(
  parameter int unsigned HALF_DIV = 6,
  parameter bit          GAIN_1X  = 1'b1,
  parameter bit          VREF_BUF = 1'b0
) (
  input  logic            CLK12M,
  input  logic            rst,
  mcp4922_dac_tx_if.slave wr,
  output logic            busy,
  output logic            done,
  output logic            cs_n,
  output logic            sck,
  output logic            sdi,
  output logic            ldac_n
);

  localparam logic [7:0] HALF_RELOAD = 8'(HALF_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CS_GAP, LDAC, FIN} state_t;

  state_t      state, state_nxt;
  logic [11:0] code_a, code_b;
  logic        pend_a, pend_b;
  logic [15:0] shreg, shreg_nxt;
  logic [7:0]  hcnt, hcnt_nxt;
  logic [4:0]  bcnt, bcnt_nxt;
  logic        cs_n_nxt, sck_nxt, sdi_nxt, ldac_n_nxt, done_nxt;
  logic        load_b;
  logic        half_end;

  function automatic logic [15:0] frame_word(input logic ch, input logic [11:0] code);
    return {ch, VREF_BUF, GAIN_1X, 1'b1, code};
  endfunction

  assign wr.in_ready = !rst;
  assign load_b      = !pend_a;
  assign half_end    = (hcnt == 8'd0);
  assign busy        = (state != IDLE && state != FIN) || pend_a || pend_b;

  // Pending codes carry no reset; only their flags do.
  always_ff @(posedge CLK12M) begin
    if (wr.in_valid && !rst) begin
      if (wr.in_ch) code_b <= wr.in_data;
      else          code_a <= wr.in_data;
    end
  end

  // A write in the LOAD cycle is ordered after the clear so it stays pending.
  always_ff @(posedge CLK12M) begin
    if (rst) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      if (state == LOAD && !load_b) pend_a <= 1'b0;
      if (state == LOAD &&  load_b) pend_b <= 1'b0;
      if (wr.in_valid) begin
        if (wr.in_ch) pend_b <= 1'b1;
        else          pend_a <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK12M) begin
    shreg <= shreg_nxt;
    if (rst) begin
      state  <= IDLE;
      hcnt   <= 8'd0;
      bcnt   <= 5'd0;
      cs_n   <= 1'b1;
      sck    <= 1'b0;
      sdi    <= 1'b0;
      ldac_n <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      hcnt   <= hcnt_nxt;
      bcnt   <= bcnt_nxt;
      cs_n   <= cs_n_nxt;
      sck    <= sck_nxt;
      sdi    <= sdi_nxt;
      ldac_n <= ldac_n_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    hcnt_nxt   = hcnt;
    bcnt_nxt   = bcnt;
    cs_n_nxt   = cs_n;
    sck_nxt    = sck;
    sdi_nxt    = sdi;
    ldac_n_nxt = ldac_n;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_a || pend_b) state_nxt = LOAD;
      end
      LOAD: begin
        shreg_nxt = frame_word(load_b, load_b ? code_b : code_a);
        sdi_nxt   = shreg_nxt[15];
        cs_n_nxt  = 1'b0;
        sck_nxt   = 1'b0;
        hcnt_nxt  = HALF_RELOAD;
        bcnt_nxt  = 5'd0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!half_end) begin
          hcnt_nxt = hcnt - 8'd1;
        end else begin
          hcnt_nxt = HALF_RELOAD;
          if (!sck) begin
            sck_nxt = 1'b1;
          end else begin
            sck_nxt  = 1'b0;
            bcnt_nxt = bcnt + 5'd1;
            // The 16th falling edge ends the frame; sdi keeps the last bit.
            if (bcnt == 5'd15) begin
              cs_n_nxt  = 1'b1;
              state_nxt = CS_GAP;
            end else begin
              shreg_nxt = {shreg[14:0], 1'b0};
              sdi_nxt   = shreg[14];
            end
          end
        end
      end
      CS_GAP: begin
        if (!half_end) begin
          hcnt_nxt = hcnt - 8'd1;
        end else if (pend_a || pend_b) begin
          state_nxt = LOAD;
        end else begin
          ldac_n_nxt = 1'b0;
          hcnt_nxt   = HALF_RELOAD;
          state_nxt  = LDAC;
        end
      end
      LDAC: begin
        if (!half_end) begin
          hcnt_nxt = hcnt - 8'd1;
        end else begin
          ldac_n_nxt = 1'b1;
          done_nxt   = 1'b1;
          state_nxt  = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mcp4922_dac_tx.sv
// Bench for mcp4922_dac_tx: directed vectors, multi-cycle corner sequences and a
// randomized run, all checked against a pin-level monitor and a pending-code model.
module tb_mcp4922_dac_tx;

  localparam int H1 = 6;
  localparam int H2 = 2;
  localparam logic GAIN1 = 1'b1;
  localparam logic VREF1 = 1'b0;

  logic CLK12M = 1'b0;
  logic rst;
  logic busy, done, cs_n, sck, sdi, ldac_n;
  logic busy2, done2, cs2_n, sck2, sdi2, ldac2_n;

  mcp4922_dac_tx_if bus ();
  mcp4922_dac_tx_if bus2 ();

  mcp4922_dac_tx #(.HALF_DIV(H1), .GAIN_1X(GAIN1), .VREF_BUF(VREF1)) u_dut (
    .CLK12M(CLK12M), .rst(rst), .wr(bus), .busy(busy), .done(done),
    .cs_n(cs_n), .sck(sck), .sdi(sdi), .ldac_n(ldac_n)
  );

  mcp4922_dac_tx #(.HALF_DIV(H2), .GAIN_1X(1'b0), .VREF_BUF(1'b1)) u_dut2 (
    .CLK12M(CLK12M), .rst(rst), .wr(bus2), .busy(busy2), .done(done2),
    .cs_n(cs2_n), .sck(sck2), .sdi(sdi2), .ldac_n(ldac2_n)
  );

  always #5 CLK12M = ~CLK12M;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor state and reference model for the main DUT
  logic [1:0]  m_flag = 2'b00;
  logic [11:0] m_val [2];
  logic [15:0] got_q [$];
  logic [15:0] cap, exp_frame;
  logic        sel, ldac_rise;
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_sdi = 1'b0, prev_ldac = 1'b1;
  logic        in_frame = 1'b0, chain = 1'b0;
  int cyc = 0, nbits = 0, cs_len = 0, unstable = 0;
  int cs_rise_cyc = 0, ldac_fall_cyc = 0, ldac_cnt = 0, done_cnt = 0;

  always @(negedge CLK12M) begin
    cyc++;
    if (rst) begin
      m_flag   = 2'b00;
      in_frame = 1'b0;
      chain    = 1'b0;
    end else begin
      if (prev_cs && !cs_n) begin
        sel = m_flag[0] ? 1'b0 : 1'b1;
        check("pending_at_load", 32'(m_flag != 2'b00), 32'd1);
        exp_frame = {sel, VREF1, GAIN1, 1'b1, m_val[sel]};
        m_flag[sel] = 1'b0;
        if (chain) check("cs_high_between_frames", 32'(cyc - cs_rise_cyc), 32'(H1 + 1));
        in_frame = 1'b1; cap = 16'd0; nbits = 0; cs_len = 0; unstable = 0;
      end
      if (in_frame && !cs_n) begin
        cs_len++;
        if (!prev_sck && sck) begin
          cap = {cap[14:0], sdi};
          nbits++;
          if (sdi !== prev_sdi) unstable++;
        end
      end
      if (!prev_cs && cs_n && in_frame) begin
        in_frame = 1'b0;
        got_q.push_back(cap);
        check("frame_word", 32'(cap), 32'(exp_frame));
        check("frame_bits", 32'(nbits), 32'd16);
        check("cs_low_cycles", 32'(cs_len), 32'(32 * H1));
        check("sdi_stable_at_sck_rise", 32'(unstable), 32'd0);
        cs_rise_cyc = cyc;
        chain = 1'b1;
      end
      if (prev_ldac && !ldac_n) begin
        check("ldac_with_nothing_pending", 32'(m_flag), 32'd0);
        check("cs_gap_cycles", 32'(cyc - cs_rise_cyc), 32'(H1));
        chain = 1'b0;
        ldac_fall_cyc = cyc;
        ldac_cnt++;
      end
      ldac_rise = !prev_ldac && ldac_n;
      if (ldac_rise) check("ldac_low_cycles", 32'(cyc - ldac_fall_cyc), 32'(H1));
      if (bus.in_valid) begin
        m_flag[bus.in_ch] = 1'b1;
        m_val[bus.in_ch]  = bus.in_data;
      end
      if (done || ldac_rise) begin
        check("done_with_ldac_rise", 32'(done), 32'(ldac_rise));
        if (done) begin
          done_cnt++;
          check("busy_at_done", 32'(busy), 32'(m_flag != 2'b00));
        end
      end
    end
    prev_cs = cs_n; prev_sck = sck; prev_sdi = sdi; prev_ldac = ldac_n;
  end

  // Frame capture for the second DUT
  logic [15:0] frames2 [$];
  logic [15:0] cap2;
  logic        p2_cs = 1'b1, p2_sck = 1'b0, p2_sdi = 1'b0, in2 = 1'b0;
  int nb2 = 0, len2 = 0, uns2 = 0, done2_cnt = 0;

  always @(negedge CLK12M) begin
    if (rst) begin
      in2 = 1'b0;
    end else begin
      if (p2_cs && !cs2_n) begin
        in2 = 1'b1; cap2 = 16'd0; nb2 = 0; len2 = 0; uns2 = 0;
      end
      if (in2 && !cs2_n) begin
        len2++;
        if (!p2_sck && sck2) begin
          cap2 = {cap2[14:0], sdi2};
          nb2++;
          if (sdi2 !== p2_sdi) uns2++;
        end
      end
      if (!p2_cs && cs2_n && in2) begin
        in2 = 1'b0;
        frames2.push_back(cap2);
      end
      if (done2) done2_cnt++;
    end
    p2_cs = cs2_n; p2_sck = sck2; p2_sdi = sdi2;
  end

  task automatic tick();
    @(negedge CLK12M);
    #1;
  endtask

  task automatic wr1(input logic ch, input logic [11:0] d);
    bus.in_valid = 1'b1; bus.in_ch = ch; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n_done, input int budget, input string name);
    int t = 0;
    while (done_cnt < n_done && t < budget) begin
      tick();
      t++;
    end
    check(name, 32'(done_cnt >= n_done), 32'd1);
  endtask

  task automatic check_frames(input string name, input int f0, input int n,
                              input logic [15:0] e0, input logic [15:0] e1);
    check({name, "_count"}, 32'(got_q.size()), 32'(f0 + n));
    if (got_q.size() >= f0 + n) begin
      check({name, "_first"}, 32'(got_q[f0]), 32'(e0));
      if (n > 1) check({name, "_second"}, 32'(got_q[f0 + 1]), 32'(e1));
    end
  endtask

  typedef struct {
    logic        ch;
    logic [11:0] data;
    logic [15:0] frame;
  } vec_t;

  vec_t tbl [6];
  int f0, l0, d0, t;

  initial begin
    tbl[0] = '{ch: 1'b1, data: 12'h123, frame: 16'hB123};
    tbl[1] = '{ch: 1'b0, data: 12'h7FF, frame: 16'h37FF};
    tbl[2] = '{ch: 1'b1, data: 12'h000, frame: 16'hB000};
    tbl[3] = '{ch: 1'b0, data: 12'hFFF, frame: 16'h3FFF};
    tbl[4] = '{ch: 1'b1, data: 12'h555, frame: 16'hB555};
    tbl[5] = '{ch: 1'b0, data: 12'h001, frame: 16'h3001};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_ch = 1'b0; bus.in_data = 12'h000;
    bus2.in_valid = 1'b0; bus2.in_ch = 1'b0; bus2.in_data = 12'h000;
    repeat (3) tick();
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_sck", 32'(sck), 32'd0);
    check("reset_sdi", 32'(sdi), 32'd0);
    check("reset_ldac_n", 32'(ldac_n), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Single write: latency, frame, LDAC
    f0 = got_q.size(); l0 = ldac_cnt; d0 = done_cnt;
    wr1(1'b0, 12'hABC);
    check("latency_cs_high_w", 32'(cs_n), 32'd1);
    check("busy_while_pending", 32'(busy), 32'd1);
    tick();
    check("latency_cs_high_load", 32'(cs_n), 32'd1);
    tick();
    check("latency_cs_low_w2", 32'(cs_n), 32'd0);
    wait_done(d0 + 1, 400, "single_done_timeout");
    repeat (3) tick();
    check_frames("single", f0, 1, 16'h3ABC, 16'h0000);
    check("single_ldac_pulses", 32'(ldac_cnt - l0), 32'd1);
    check("single_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("single_busy_after", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      f0 = got_q.size(); l0 = ldac_cnt; d0 = done_cnt;
      wr1(tbl[i].ch, tbl[i].data);
      wait_done(d0 + 1, 400, "table_done_timeout");
      repeat (3) tick();
      check_frames("table", f0, 1, tbl[i].frame, 16'h0000);
      check("table_ldac_pulses", 32'(ldac_cnt - l0), 32'd1);
    end

    // Back-to-back writes to both channels: A goes first, one LDAC
    f0 = got_q.size(); l0 = ldac_cnt; d0 = done_cnt;
    wr1(1'b1, 12'h123);
    wr1(1'b0, 12'h7FF);
    wait_done(d0 + 1, 900, "b2b_done_timeout");
    repeat (20) tick();
    check_frames("b2b", f0, 2, 16'h37FF, 16'hB123);
    check("b2b_ldac_pulses", 32'(ldac_cnt - l0), 32'd1);
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Overwrite before LOAD
    f0 = got_q.size(); l0 = ldac_cnt; d0 = done_cnt;
    wr1(1'b0, 12'h111);
    wr1(1'b0, 12'h222);
    wait_done(d0 + 1, 400, "overwrite_done_timeout");
    repeat (20) tick();
    check_frames("overwrite", f0, 1, 16'h3222, 16'h0000);
    check("overwrite_ldac_pulses", 32'(ldac_cnt - l0), 32'd1);

    // Write during SHIFT chains a second frame with no LDAC between
    f0 = got_q.size(); l0 = ldac_cnt; d0 = done_cnt;
    wr1(1'b0, 12'h0F0);
    repeat (50) tick();
    check("mid_shift_cs_low", 32'(cs_n), 32'd0);
    wr1(1'b0, 12'h555);
    wait_done(d0 + 1, 900, "shift_write_done_timeout");
    repeat (20) tick();
    check_frames("shift_write", f0, 2, 16'h30F0, 16'h3555);
    check("shift_write_ldac_pulses", 32'(ldac_cnt - l0), 32'd1);

    // Write during LDAC gets its own frame and LDAC
    f0 = got_q.size(); l0 = ldac_cnt; d0 = done_cnt;
    wr1(1'b1, 12'h0C3);
    t = 0;
    while (ldac_n !== 1'b0 && t < 400) begin tick(); t++; end
    check("ldac_wait_timeout", 32'(ldac_n), 32'd0);
    wr1(1'b1, 12'h0AA);
    wait_done(d0 + 2, 900, "ldac_write_done_timeout");
    repeat (5) tick();
    check_frames("ldac_write", f0, 2, 16'hB0C3, 16'hB0AA);
    check("ldac_write_ldac_pulses", 32'(ldac_cnt - l0), 32'd2);

    // Reset in the middle of a frame
    f0 = got_q.size(); l0 = ldac_cnt; d0 = done_cnt;
    wr1(1'b1, 12'h3C3);
    t = 0;
    while (!(in_frame && nbits == 8) && t < 400) begin tick(); t++; end
    check("bit8_wait_timeout", 32'(nbits), 32'd8);
    rst = 1'b1;
    tick();
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_sdi", 32'(sdi), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ldac_n", 32'(ldac_n), 32'd1);
    rst = 1'b0;
    repeat (300) tick();
    check("abort_no_ldac", 32'(ldac_cnt - l0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_frame", 32'(got_q.size()), 32'(f0));
    wr1(1'b0, 12'h9A5);
    wait_done(d0 + 1, 400, "post_abort_done_timeout");
    repeat (3) tick();
    check_frames("post_abort", f0, 1, 16'h39A5, 16'h0000);

    // Second instance: 2x gain, buffered VREF, fastest SCK
    d0 = done2_cnt;
    bus2.in_valid = 1'b1; bus2.in_ch = 1'b1; bus2.in_data = 12'hFFF;
    tick();
    bus2.in_valid = 1'b0;
    t = 0;
    while (done2_cnt == d0 && t < 200) begin tick(); t++; end
    check("dut2_done_timeout", 32'(done2_cnt - d0), 32'd1);
    check("dut2_frame_count", 32'(frames2.size()), 32'd1);
    if (frames2.size() > 0) check("dut2_frame", 32'(frames2[0]), 32'hDFFF);
    check("dut2_bits", 32'(nb2), 32'd16);
    check("dut2_cs_low_cycles", 32'(len2), 32'(32 * H2));
    check("dut2_sdi_stable", 32'(uns2), 32'd0);

    // Random traffic checked by the monitor's pending-code model
    f0 = got_q.size();
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        bus.in_valid = 1'b1;
        bus.in_ch    = 1'($urandom_range(0, 1));
        bus.in_data  = 12'($urandom);
      end
      tick();
      bus.in_valid = 1'b0;
    end
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin tick(); t++; end
    check("random_drain", 32'(busy), 32'd0);
    check("random_all_sent", 32'(m_flag), 32'd0);
    check("random_frames_seen", 32'(got_q.size() > f0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
